// File: rtl/toggle_hs_pkg.sv
// Shared types and default sizes for the toggle handshake receiver and its
// matching transmitter.
//   hs_state_e      : receiver state (IDLE waits for a request, HOLD presents a word)
//   HS_DW           : default payload width
//   HS_SYNC_STAGES  : default synchroniser depth (legal 2..4)
//   HS_CNT_W        : default transfer counter width
package toggle_hs_pkg;

    localparam int unsigned HS_DW          = 32;
    localparam int unsigned HS_SYNC_STAGES = 2;
    localparam int unsigned HS_CNT_W       = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hs_state_e;

endpackage : toggle_hs_pkg

// File: rtl/synch_ffn.sv
// N-stage single-bit synchroniser for a level/toggle crossing into clk.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears every stage to 0
//   d       : asynchronous input bit
//   q       : synchronised copy, STAGES clk edges behind d
module synch_ffn #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Plain shift chain; the first flop is the only one allowed to go metastable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule : synch_ffn

// File: rtl/toggle_hs_rx.sv
// Receiving end of a 2-phase toggle req/ack handshake. A toggle on req_tgl
// announces a new req_data word from the sender domain; the word is captured
// into dout_data, offered on a valid/ready interface, and ack_tgl toggles on
// the edge the local consumer takes it.
//   clk        : local clock
//   reset_n    : asynchronous active-low reset
//   req_tgl    : request toggle from the sender domain (asynchronous)
//   req_data   : payload, held stable by the sender until the matching ack
//   ack_tgl    : acknowledge toggle back to the sender (registered)
//   dout_valid : captured word available
//   dout_ready : consumer accepts the word
//   dout_data  : captured word (registered)
//   proto_err  : sticky flag, sender toggled again before being acknowledged
//   xfer_cnt   : completed transfer count, wraps silently
module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter int unsigned DW          = HS_DW,
    parameter int unsigned SYNC_STAGES = HS_SYNC_STAGES,
    parameter int unsigned CNT_W       = HS_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_tgl,
    input  logic [DW-1:0]    req_data,
    output logic             ack_tgl,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [DW-1:0]    dout_data,
    output logic             proto_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    hs_state_e state;
    logic      req_s;
    logic      req_seen;
    logic      new_req_c;

    // Bring the request toggle into the local domain.
    synch_ffn #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (req_tgl),
        .q       (req_s)
    );

    // A request is pending whenever the synchronised toggle differs from the
    // last toggle value we consumed.
    assign new_req_c = req_s ^ req_seen;

    // Handshake FSM; every output is a flop updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_seen   <= 1'b0;
            ack_tgl    <= 1'b0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            proto_err  <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_data is only guaranteed stable here, so it is sampled once.
                    if (new_req_c) begin
                        dout_data  <= req_data;
                        req_seen   <= req_s;
                        dout_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    // Sender toggled again before our ack: record it, keep the
                    // held word; the newer request is picked up from IDLE.
                    if (new_req_c) begin
                        proto_err <= 1'b1;
                    end
                    if (dout_ready) begin
                        ack_tgl    <= ~ack_tgl;
                        dout_valid <= 1'b0;
                        xfer_cnt   <= xfer_cnt + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : toggle_hs_rx

// File: tb/tb_toggle_hs_rx.sv
// Self-checking bench for toggle_hs_rx: a queue model predicts when each word
// becomes valid, what it carries, the ack parity, the transfer count and the
// error flag, and is compared on every falling edge.
module tb_toggle_hs_rx;

    localparam int unsigned DW = 32;
    localparam int unsigned S  = 2;
    localparam int unsigned CW = 4;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          req_tgl    = 1'b0;
    logic [DW-1:0] req_data   = '0;
    logic          dout_ready = 1'b0;
    logic          ack_tgl;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic          proto_err;
    logic [CW-1:0] xfer_cnt;

    toggle_hs_rx #(
        .DW          (DW),
        .SYNC_STAGES (S),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_tgl    (req_tgl),
        .req_data   (req_data),
        .ack_tgl    (ack_tgl),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .proto_err  (proto_err),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: each request is a word plus the cycle its toggle was launched.
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   push;
    } item_t;

    item_t       q[$];
    int unsigned m_cnt     = 0;
    int unsigned last_done = 0;
    logic        m_err     = 1'b0;
    bit          chk_en    = 1'b0;
    int          checks    = 0;
    int          failures  = 0;

    bit          ev;
    int unsigned head_at;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Head word is visible S+1 edges after its toggle, and never earlier than
    // the edge after the previous word completed.
    always @(negedge clk) begin
        if (chk_en) begin
            ev = 1'b0;
            if (q.size() > 0) begin
                head_at = q[0].push + S + 1;
                if (last_done + 1 > head_at) head_at = last_done + 1;
                ev = (cyc >= head_at);
            end
            chk("valid", 32'(dout_valid), 32'(ev));
            if (ev) chk("data", dout_data, q[0].data);
            chk("ack", 32'(ack_tgl), 32'(m_cnt % 2));
            chk("cnt", 32'(xfer_cnt), 32'(m_cnt % (1 << CW)));
            chk("err", 32'(proto_err), 32'(m_err));
            // A later toggle reaching the receiver while a word is held is a violation.
            if (ev && q.size() >= 2 && q[1].push + S + 1 <= cyc + 1) m_err = 1'b1;
            if (ev && dout_ready) begin
                void'(q.pop_front());
                m_cnt++;
                last_done = cyc + 1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        req_tgl = 1'b0;
        dout_ready = 1'b0;
        q.delete();
        m_cnt = 0;
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        last_done = cyc;
        chk_en    = 1'b1;
    endtask

    task automatic toggle_req(input logic [DW-1:0] d);
        @(posedge clk); #1;
        req_data = d;
        req_tgl  = ~req_tgl;
        q.push_back(item_t'{data: d, push: cyc});
    endtask

    task automatic wait_ack(input logic a0);
        int n;
        n = 0;
        while (ack_tgl === a0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_wait", 32'(ack_tgl !== a0), 32'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (dout_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_wait", 32'(dout_valid), 32'd1);
    endtask

    task automatic send(input logic [DW-1:0] d);
        logic a0;
        a0 = ack_tgl;
        toggle_req(d);
        wait_ack(a0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    bit rnd_done;

    initial begin
        // Reset state held for 10 cycles.
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_data", dout_data, 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);

        // Single transfer: valid exactly S+1 = 3 edges after the toggle.
        toggle_req(32'hDEADBEEF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lat_early", 32'(dout_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", 32'(dout_valid), 32'd1);
        chk("lat_data", dout_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        chk("one_ack", 32'(ack_tgl), 32'd1);
        chk("one_valid", 32'(dout_valid), 32'd0);
        chk("one_cnt", 32'(xfer_cnt), 32'd1);
        dout_ready = 1'b0;

        // Backpressure: req_data changes while the word is held.
        toggle_req(32'hDEADBEEF);
        wait_valid();
        repeat (20) begin
            @(posedge clk); #1;
            req_data = 32'h12345678;
        end
        chk("bp_data", dout_data, 32'hDEADBEEF);
        chk("bp_ack", 32'(ack_tgl), 32'd1);
        dout_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_done_ack", 32'(ack_tgl), 32'd0);
        chk("bp_done_cnt", 32'(xfer_cnt), 32'd2);
        dout_ready = 1'b0;

        // Streaming 8 words, sender toggling on each ack.
        do_reset();
        dout_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(32'(i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("str_cnt", 32'(xfer_cnt), 32'd8);
        chk("str_ack", 32'(ack_tgl), 32'd0);
        chk("str_err", 32'(proto_err), 32'd0);

        // Protocol error: second toggle while the first word is held.
        do_reset();
        toggle_req(32'h11);
        wait_valid();
        repeat (2) @(posedge clk);
        toggle_req(32'hA5);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pe_err", 32'(proto_err), 32'd1);
        chk("pe_hold", dout_data, 32'h11);
        @(posedge clk); #1;
        dout_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("pe_cnt", 32'(xfer_cnt), 32'd2);
        chk("pe_last", dout_data, 32'hA5);
        chk("pe_sticky", 32'(proto_err), 32'd1);
        do_reset();
        @(negedge clk);
        chk("pe_clear", 32'(proto_err), 32'd0);

        // Reset mid-transfer: outputs drop without waiting for a clock.
        dout_ready = 1'b1;
        send(32'hCAFE0001);
        dout_ready = 1'b0;
        toggle_req(32'hCAFE0002);
        wait_valid();
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_valid", 32'(dout_valid), 32'd0);
        chk("mid_ack", 32'(ack_tgl), 32'd0);
        do_reset();

        // Counter wrap with a 4-bit counter: 17 transfers leave 1.
        dout_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(32'h100 + 32'(i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wrap_cnt", 32'(xfer_cnt), 32'd1);

        // Random traffic with random backpressure.
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    send($urandom);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    dout_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dout_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rnd_cnt", 32'(xfer_cnt), 32'(40 % (1 << CW)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_toggle_hs_rx
